rtl_kernel_1_burst_sequencer: RTL

RTL_KERNEL_1_BURST_SEQUENCER -- requirements
Module: rtl_kernel_1_burst_sequencer

---
 rtl/rtl_kernel_1_burst_sequencer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/rtl_kernel_1_burst_sequencer.sv
// Burst sequencer: splits a beat-count transfer into bursts that never cross a 4 KiB page,
// with a bounded number of issued-but-uncompleted bursts and a start/idle/done control handshake.
module rtl_kernel_1_burst_sequencer #(
    parameter int C_ADDR_WIDTH      = 64,
    parameter int C_XFER_SIZE_WIDTH = 32,
    parameter int C_BURST_LEN       = 16,
    parameter int C_BYTES_PER_BEAT  = 64,
    parameter int C_MAX_OUTSTANDING = 4
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic                         ap_start,
    output logic                         ap_idle,
    output logic                         ap_done,
    output logic                         ap_ready,
    input  logic [C_ADDR_WIDTH-1:0]      cfg_addr,
    input  logic [C_XFER_SIZE_WIDTH-1:0] cfg_num_beats,
    output logic                         req_valid,
    input  logic                         req_ready,
    output logic [C_ADDR_WIDTH-1:0]      req_addr,
    output logic [7:0]                   req_len,
    input  logic                         cmpl_valid,
    output logic [3:0]                   outstanding,
    output logic                         cmpl_err
);

    localparam int BEAT_SHIFT = $clog2(C_BYTES_PER_BEAT);
    localparam int PAGE_BEATS = 4096 / C_BYTES_PER_BEAT;
    localparam int CW         = (C_XFER_SIZE_WIDTH > 14) ? C_XFER_SIZE_WIDTH : 14;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [C_ADDR_WIDTH-1:0]      addr_q;
    logic [C_XFER_SIZE_WIDTH-1:0] remaining_q;
    logic [C_XFER_SIZE_WIDTH-1:0] remaining_after;
    logic [C_ADDR_WIDTH-1:0]      addr_step;
    logic [8:0]                   hs_beats;
    logic [CW-1:0]                to_boundary;
    logic [CW-1:0]                burst_beats;
    logic [7:0]                   burst_len;
    logic [3:0]                   outstanding_next;
    logic                         handshake;
    logic                         cmpl_take;
    logic                         cmpl_spurious;
    logic                         last_burst;
    logic                         start_accept;
    logic                         can_issue;

    // Request channel: req_valid/req_addr/req_len are registered; once req_valid rises the
    // triple holds until the cycle where req_valid && req_ready, which is the only transfer point.
    always_comb begin
        handshake       = req_valid && req_ready;
        cmpl_take       = cmpl_valid && (outstanding != 4'd0);
        cmpl_spurious   = cmpl_valid && (outstanding == 4'd0);
        start_accept    = (state == S_IDLE) && ap_start;
        hs_beats        = {1'b0, req_len} + 9'd1;
        remaining_after = remaining_q - C_XFER_SIZE_WIDTH'(hs_beats);
        last_burst      = (remaining_after == '0);
        addr_step       = C_ADDR_WIDTH'(hs_beats) << BEAT_SHIFT;
    end

    always_comb begin
        outstanding_next = outstanding;
        if (handshake && !cmpl_take) begin
            outstanding_next = outstanding + 4'd1;
        end else if (!handshake && cmpl_take) begin
            outstanding_next = outstanding - 4'd1;
        end
    end

    // Burst size is the smallest of what is left, the burst cap, and the room left in the page.
    always_comb begin
        to_boundary = CW'(PAGE_BEATS) - CW'(addr_q[11:0] >> BEAT_SHIFT);
        burst_beats = CW'(remaining_q);
        if (burst_beats > CW'(C_BURST_LEN)) begin
            burst_beats = CW'(C_BURST_LEN);
        end
        if (burst_beats > to_boundary) begin
            burst_beats = to_boundary;
        end
        burst_len = 8'(burst_beats - CW'(1));
    end

    always_comb begin
        can_issue = (state == S_ISSUE) && !req_valid && (remaining_q != '0)
                    && (outstanding_next < 4'(C_MAX_OUTSTANDING));
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (ap_start) begin
                    state_next = (cfg_num_beats == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (handshake && last_burst) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (outstanding == 4'd0) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        ap_idle  = (state == S_IDLE);
        ap_done  = (state == S_DONE);
        ap_ready = (state == S_DONE);
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            addr_q      <= '0;
            remaining_q <= '0;
            req_valid   <= 1'b0;
            req_addr    <= '0;
            req_len     <= '0;
            outstanding <= '0;
            cmpl_err    <= 1'b0;
        end else begin
            outstanding <= outstanding_next;

            // A spurious completion in the same cycle as a start still leaves the flag raised.
            if (cmpl_spurious) begin
                cmpl_err <= 1'b1;
            end else if (start_accept) begin
                cmpl_err <= 1'b0;
            end

            if (start_accept) begin
                addr_q      <= cfg_addr;
                remaining_q <= cfg_num_beats;
            end else if (handshake) begin
                addr_q      <= addr_q + addr_step;
                remaining_q <= remaining_after;
            end

            if (handshake) begin
                req_valid <= 1'b0;
            end else if (can_issue) begin
                req_valid <= 1'b1;
                req_addr  <= addr_q;
                req_len   <= burst_len;
            end
        end
    end

endmodule
